// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pkg
//  Description : Shared command, error-code and state constants for the SDRAM
//                power-up sequence checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

  localparam logic [3:0] C_CMD_NOP  = 4'b0111;
  localparam logic [3:0] C_CMD_PRE  = 4'b0010;
  localparam logic [3:0] C_CMD_AREF = 4'b0001;
  localparam logic [3:0] C_CMD_LMR  = 4'b0000;

  localparam logic [2:0] C_ERR_NONE     = 3'd0;
  localparam logic [2:0] C_ERR_EARLY    = 3'd1;
  localparam logic [2:0] C_ERR_GAP      = 3'd2;
  localparam logic [2:0] C_ERR_SEQ      = 3'd3;
  localparam logic [2:0] C_ERR_PRE_A10  = 3'd4;
  localparam logic [2:0] C_ERR_MR_BA    = 3'd5;
  localparam logic [2:0] C_ERR_AREF_FEW = 3'd6;

  localparam logic [2:0] C_ST_POWERUP  = 3'd0;
  localparam logic [2:0] C_ST_EXP_PRE  = 3'd1;
  localparam logic [2:0] C_ST_GAP_TRP  = 3'd2;
  localparam logic [2:0] C_ST_GAP_TRFC = 3'd3;
  localparam logic [2:0] C_ST_GAP_TMRD = 3'd4;
  localparam logic [2:0] C_ST_EXP_AREF = 3'd5;
  localparam logic [2:0] C_ST_DONE     = 3'd6;
  localparam logic [2:0] C_ST_ERR      = 3'd7;

  typedef enum logic [2:0] {
    KIND_NOP,
    KIND_PRE,
    KIND_AREF,
    KIND_LMR,
    KIND_OTHER
  } cmd_kind_t;

  // Deselect (CS_N high) is folded into NOP regardless of the other strobes.
  function automatic cmd_kind_t decode_cmd(input logic [3:0] cmd);
    cmd_kind_t k;
    if (cmd[3]) begin
      k = KIND_NOP;
    end else begin
      case (cmd)
        C_CMD_NOP:  k = KIND_NOP;
        C_CMD_PRE:  k = KIND_PRE;
        C_CMD_AREF: k = KIND_AREF;
        C_CMD_LMR:  k = KIND_LMR;
        default:    k = KIND_OTHER;
      endcase
    end
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_gap_timer
//  Description : Loadable 4-bit down-counter with a zero flag, used to time
//                the tRP / tRFC / tMRD windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_gap_timer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_val,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule
`default_nettype wire

// File: rtl/sdram_init_checker.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_init_checker
//  Description : Bus monitor that validates the SDRAM power-up sequence,
//                captures the mode word and reports init-ok or a sticky error.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_init_checker
  import sdram_pkg::*;
#(
  parameter int WAIT_CYC = 20000,
  parameter int TRP      = 2,
  parameter int TRFC     = 7,
  parameter int TMRD     = 3,
  parameter int AREF_MIN = 8
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst,
  input  logic [3:0]  i_cmd,
  input  logic [1:0]  i_ba,
  input  logic [12:0] i_addr,
  output logic        o_init_ok,
  output logic [12:0] o_mode_reg,
  output logic        o_mode_valid,
  output logic [3:0]  o_aref_cnt,
  output logic        o_err,
  output logic [2:0]  o_err_code
);

  localparam int CNT_W = (WAIT_CYC < 1) ? 1 : $clog2(WAIT_CYC + 1);
  localparam logic [CNT_W-1:0] C_WAIT_LAST = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] C_WAIT_FULL = CNT_W'(WAIT_CYC);
  localparam logic [3:0] C_TRP_LD   = 4'(TRP - 1);
  localparam logic [3:0] C_TRFC_LD  = 4'(TRFC - 1);
  localparam logic [3:0] C_TMRD_LD  = 4'(TMRD - 1);
  localparam logic [3:0] C_AREF_MIN = 4'(AREF_MIN);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_pwr_cnt;
  logic [3:0]       r_aref_cnt;
  logic [12:0]      r_mode_reg;
  logic             r_mode_valid;
  logic             r_init_ok;
  logic             r_err;
  logic [2:0]       r_err_code;

  cmd_kind_t  w_kind;
  logic [2:0] w_state_eff;
  logic [2:0] w_state_nxt;
  logic       w_viol;
  logic [2:0] w_code;
  logic       w_tmr_load;
  logic [3:0] w_tmr_val;
  logic       w_tmr_zero;
  logic       w_aref_inc;
  logic       w_mode_cap;

  assign w_kind = decode_cmd(i_cmd);

  sdram_gap_timer u_gap_timer (
    .i_clk  (i_sysclk),
    .i_rst  (i_sysrst),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_zero (w_tmr_zero)
  );

  always_comb begin
    w_state_eff = r_state;
    w_viol      = 1'b0;
    w_code      = C_ERR_NONE;
    w_tmr_load  = 1'b0;
    w_tmr_val   = 4'd0;
    w_aref_inc  = 1'b0;
    w_mode_cap  = 1'b0;

    // An expired gap window behaves as the state it leads to, so a command
    // landing exactly on the boundary cycle is judged by the following state.
    if (w_tmr_zero) begin
      case (r_state)
        C_ST_GAP_TRP, C_ST_GAP_TRFC: w_state_eff = C_ST_EXP_AREF;
        C_ST_GAP_TMRD:               w_state_eff = C_ST_DONE;
        default:                     w_state_eff = r_state;
      endcase
    end
    w_state_nxt = w_state_eff;

    case (w_state_eff)
      C_ST_POWERUP: begin
        if (w_kind != KIND_NOP) begin
          w_viol = 1'b1;
          w_code = C_ERR_EARLY;
        end else if (r_pwr_cnt >= C_WAIT_LAST) begin
          w_state_nxt = C_ST_EXP_PRE;
        end
      end
      C_ST_EXP_PRE: begin
        if (w_kind == KIND_PRE) begin
          if (i_addr[10]) begin
            w_tmr_load  = 1'b1;
            w_tmr_val   = C_TRP_LD;
            w_state_nxt = C_ST_GAP_TRP;
          end else begin
            w_viol = 1'b1;
            w_code = C_ERR_PRE_A10;
          end
        end else if (w_kind != KIND_NOP) begin
          w_viol = 1'b1;
          w_code = C_ERR_SEQ;
        end
      end
      C_ST_GAP_TRP, C_ST_GAP_TRFC, C_ST_GAP_TMRD: begin
        if (w_kind != KIND_NOP) begin
          w_viol = 1'b1;
          w_code = C_ERR_GAP;
        end
      end
      C_ST_EXP_AREF: begin
        case (w_kind)
          KIND_NOP: ;
          KIND_AREF: begin
            w_aref_inc  = 1'b1;
            w_tmr_load  = 1'b1;
            w_tmr_val   = C_TRFC_LD;
            w_state_nxt = C_ST_GAP_TRFC;
          end
          KIND_LMR: begin
            if (r_aref_cnt < C_AREF_MIN) begin
              w_viol = 1'b1;
              w_code = C_ERR_AREF_FEW;
            end else if (i_ba != 2'd0) begin
              w_viol = 1'b1;
              w_code = C_ERR_MR_BA;
            end else begin
              w_mode_cap  = 1'b1;
              w_tmr_load  = 1'b1;
              w_tmr_val   = C_TMRD_LD;
              w_state_nxt = C_ST_GAP_TMRD;
            end
          end
          default: begin
            w_viol = 1'b1;
            w_code = C_ERR_SEQ;
          end
        endcase
      end
      default: ;
    endcase

    if (w_viol) begin
      w_state_nxt = C_ST_ERR;
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      r_state      <= C_ST_POWERUP;
      r_pwr_cnt    <= '0;
      r_aref_cnt   <= 4'd0;
      r_mode_reg   <= 13'd0;
      r_mode_valid <= 1'b0;
      r_init_ok    <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= C_ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      if (r_pwr_cnt != C_WAIT_FULL) begin
        r_pwr_cnt <= r_pwr_cnt + CNT_W'(1);
      end
      if (w_aref_inc && (r_aref_cnt != 4'hF)) begin
        r_aref_cnt <= r_aref_cnt + 4'd1;
      end
      if (w_mode_cap) begin
        r_mode_reg   <= i_addr;
        r_mode_valid <= 1'b1;
      end
      if (w_state_nxt == C_ST_DONE) begin
        r_init_ok <= 1'b1;
      end
      if (w_viol && !r_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_code;
      end
    end
  end

  assign o_init_ok    = r_init_ok;
  assign o_mode_reg   = r_mode_reg;
  assign o_mode_valid = r_mode_valid;
  assign o_aref_cnt   = r_aref_cnt;
  assign o_err        = r_err;
  assign o_err_code   = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_init_checker
//  Description : Self-checking bench: table-driven sequences, hand-written
//                corner cases and randomized runs against a cycle-stamp model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_init_checker;

  localparam int W        = 300;
  localparam int TRP      = 2;
  localparam int TRFC     = 7;
  localparam int TMRD     = 3;
  localparam int AREF_MIN = 8;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] LMR  = 4'b0000;
  localparam logic [3:0] ACT  = 4'b0011;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [3:0]  cmd  = NOP;
  logic [1:0]  ba   = 2'd0;
  logic [12:0] addr = 13'd0;
  logic        ok, mv, err;
  logic [12:0] mode;
  logic [3:0]  aref;
  logic [2:0]  code;

  always #5 clk = ~clk;

  sdram_init_checker #(
    .WAIT_CYC (W),
    .TRP      (TRP),
    .TRFC     (TRFC),
    .TMRD     (TMRD),
    .AREF_MIN (AREF_MIN)
  ) u_dut (
    .i_sysclk     (clk),
    .i_sysrst     (rst),
    .i_cmd        (cmd),
    .i_ba         (ba),
    .i_addr       (addr),
    .o_init_ok    (ok),
    .o_mode_reg   (mode),
    .o_mode_valid (mv),
    .o_aref_cnt   (aref),
    .o_err        (err),
    .o_err_code   (code)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: judges each command from cycle stamps since reset.
  int          m_cyc, m_aref, m_lmr_cyc, m_last, m_gap;
  bit          m_pre, m_lmr, m_have, m_err, m_ok, m_mv;
  logic [2:0]  m_code;
  logic [12:0] m_mode;

  typedef struct {
    string       name;
    int          pre_at;
    bit          a10;
    int          pre_gap;
    int          n_aref;
    int          aref_gap;
    int          lmr_gap;
    logic [1:0]  lmr_ba;
    logic [12:0] lmr_addr;
    bit          e_err;
    logic [2:0]  e_code;
    bit          e_ok;
    logic [3:0]  e_aref;
    bit          e_mv;
    logic [12:0] e_mode;
  } seq_t;

  seq_t tbl[8];

  function automatic seq_t mk(input string nm, input int pre_at, input bit a10,
                              input int n_aref, input int aref_gap, input int lmr_gap,
                              input logic [1:0] lba, input logic [12:0] laddr,
                              input bit e_err, input logic [2:0] e_code, input bit e_ok,
                              input logic [3:0] e_aref, input bit e_mv,
                              input logic [12:0] e_mode);
    seq_t s;
    s.name = nm;      s.pre_at = pre_at;     s.a10 = a10;       s.pre_gap = TRP;
    s.n_aref = n_aref; s.aref_gap = aref_gap; s.lmr_gap = lmr_gap;
    s.lmr_ba = lba;   s.lmr_addr = laddr;    s.e_err = e_err;   s.e_code = e_code;
    s.e_ok = e_ok;    s.e_aref = e_aref;     s.e_mv = e_mv;     s.e_mode = e_mode;
    return s;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [22:0] dut_vec();
    return {ok, mv, mode, aref, err, code};
  endfunction

  function automatic logic [22:0] model_vec();
    return {m_ok, m_mv, m_mode, 4'(m_aref), m_err, m_code};
  endfunction

  function automatic void model_reset();
    m_cyc = 0; m_aref = 0; m_lmr_cyc = 0; m_last = 0; m_gap = 0;
    m_pre = 0; m_lmr = 0; m_have = 0; m_err = 0; m_ok = 0; m_mv = 0;
    m_code = 3'd0; m_mode = 13'd0;
  endfunction

  function automatic void model_step(input logic [3:0] c, input logic [1:0] b,
                                     input logic [12:0] a);
    int  t;
    bit  is_nop;
    int  e;
    t      = m_cyc;
    is_nop = c[3] || (c == NOP);
    e      = 0;
    if (!m_err && !m_ok) begin
      if (m_lmr && (t >= m_lmr_cyc + TMRD)) begin
        m_ok = 1;
      end else if (!is_nop) begin
        if (t < W) e = 1;
        else if (m_have && (t < m_last + m_gap)) e = 2;
        else if (!m_pre) begin
          if (c == PRE && a[10]) begin
            m_pre = 1; m_have = 1; m_last = t; m_gap = TRP;
          end else if (c == PRE) e = 4;
          else e = 3;
        end else if (c == AREF) begin
          if (m_aref < 15) m_aref++;
          m_last = t; m_gap = TRFC;
        end else if (c == LMR) begin
          if (m_aref < AREF_MIN) e = 6;
          else if (b != 2'd0) e = 5;
          else begin
            m_mode = a; m_mv = 1; m_lmr = 1; m_lmr_cyc = t; m_last = t; m_gap = TMRD;
          end
        end else e = 3;
        if (e != 0) begin
          m_err = 1; m_code = 3'(e);
        end
      end
    end
    m_cyc++;
  endfunction

  task automatic tick(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    cmd = c; ba = b; addr = a;
    model_step(c, b, a);
    @(posedge clk);
    #1;
    check($sformatf("cycle%0d", m_cyc), {9'd0, dut_vec()}, {9'd0, model_vec()});
  endtask

  task automatic nop();
    logic [3:0] c;
    c = ($urandom_range(0, 1) == 0) ? NOP : {1'b1, 3'($urandom)};
    tick(c, 2'($urandom), 13'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd = NOP;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_outputs", {9'd0, dut_vec()}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic run_seq(input seq_t s, input bit with_rst);
    logic [12:0] pa;
    if (with_rst) do_reset();
    for (int i = 0; i < s.pre_at; i++) nop();
    pa = (13'($urandom) & 13'h1BFF) | (s.a10 ? 13'h0400 : 13'h0000);
    tick(PRE, 2'($urandom), pa);
    repeat (s.pre_gap - 1) nop();
    for (int i = 0; i < s.n_aref; i++) begin
      tick(AREF, 2'($urandom), 13'($urandom));
      repeat (((i == s.n_aref - 1) ? s.lmr_gap : s.aref_gap) - 1) nop();
    end
    tick(LMR, s.lmr_ba, s.lmr_addr);
    repeat (TMRD + 2) nop();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, limit 2000000 time units");
    $fatal(1);
  end

  initial begin
    seq_t s;
    tbl[0] = mk("legal",     W,     1, 8,  7, 7, 2'd0, 13'h037,  0, 3'd0, 1, 4'd8,  1, 13'h037);
    tbl[1] = mk("early",     W - 1, 1, 8,  7, 7, 2'd0, 13'h037,  1, 3'd1, 0, 4'd0,  0, 13'h000);
    tbl[2] = mk("gap6",      W,     1, 8,  6, 7, 2'd0, 13'h037,  1, 3'd2, 0, 4'd1,  0, 13'h000);
    tbl[3] = mk("few_aref",  W,     1, 7,  7, 7, 2'd0, 13'h037,  1, 3'd6, 0, 4'd7,  0, 13'h000);
    tbl[4] = mk("mr_ba",     W,     1, 8,  7, 7, 2'd1, 13'h037,  1, 3'd5, 0, 4'd8,  0, 13'h000);
    tbl[5] = mk("pre_a10",   W,     0, 8,  7, 7, 2'd0, 13'h037,  1, 3'd4, 0, 4'd0,  0, 13'h000);
    tbl[6] = mk("legal10",   W + 5, 1, 10, 8, 9, 2'd0, 13'h1ABC, 0, 3'd0, 1, 4'd10, 1, 13'h1ABC);
    tbl[7] = mk("zero_aref", W,     1, 0,  7, 7, 2'd0, 13'h037,  1, 3'd6, 0, 4'd0,  0, 13'h000);

    for (int k = 0; k < 8; k++) begin
      run_seq(tbl[k], 1'b1);
      check({tbl[k].name, "_err"},  {31'd0, err},  {31'd0, tbl[k].e_err});
      check({tbl[k].name, "_code"}, {29'd0, code}, {29'd0, tbl[k].e_code});
      check({tbl[k].name, "_ok"},   {31'd0, ok},   {31'd0, tbl[k].e_ok});
      check({tbl[k].name, "_aref"}, {28'd0, aref}, {28'd0, tbl[k].e_aref});
      check({tbl[k].name, "_mv"},   {31'd0, mv},   {31'd0, tbl[k].e_mv});
      check({tbl[k].name, "_mode"}, {19'd0, mode}, {19'd0, tbl[k].e_mode});
    end

    // init_ok rises exactly TMRD+1 cycles after the LMR cycle
    do_reset();
    for (int i = 0; i < W; i++) nop();
    tick(PRE, 2'd0, 13'h0400);
    repeat (TRP - 1) nop();
    for (int i = 0; i < 8; i++) begin
      tick(AREF, 2'd0, 13'd0);
      repeat (TRFC - 1) nop();
    end
    tick(LMR, 2'd0, 13'h037);
    check("mode_after_lmr", {19'd0, mode}, 32'h037);
    check("mv_after_lmr", {31'd0, mv}, 32'd1);
    repeat (TMRD - 1) nop();
    check("ok_not_yet", {31'd0, ok}, 32'd0);
    nop();
    check("ok_rise", {31'd0, ok}, 32'd1);
    tick(ACT, 2'd3, 13'd0);
    tick(PRE, 2'd0, 13'd0);
    check("done_accepts_all", {31'd0, err}, 32'd0);

    // reset in the middle of the refresh phase, then a fresh legal sequence
    do_reset();
    for (int i = 0; i < W; i++) nop();
    tick(PRE, 2'd0, 13'h0400);
    repeat (TRP - 1) nop();
    for (int i = 0; i < 4; i++) begin
      tick(AREF, 2'd0, 13'd0);
      repeat (3) nop();
      if (i < 3) repeat (TRFC - 4) nop();
    end
    check("mid_aref", {28'd0, aref}, 32'd4);
    do_reset();
    run_seq(tbl[0], 1'b0);
    check("restart_ok", {31'd0, ok}, 32'd1);
    check("restart_aref", {28'd0, aref}, 32'd8);

    for (int r = 0; r < 20; r++) begin
      s = tbl[0];
      s.name     = "rand";
      s.pre_at   = ($urandom_range(0, 7) == 0) ? W - 1 : W + int'($urandom_range(0, 3));
      s.a10      = ($urandom_range(0, 9) != 0);
      s.pre_gap  = TRP + int'($urandom_range(0, 2)) - (($urandom_range(0, 7) == 0) ? 1 : 0);
      s.aref_gap = TRFC + int'($urandom_range(0, 2)) - (($urandom_range(0, 7) == 0) ? 1 : 0);
      s.lmr_gap  = TRFC + int'($urandom_range(0, 2)) - (($urandom_range(0, 7) == 0) ? 1 : 0);
      s.n_aref   = int'($urandom_range(6, 10));
      s.lmr_ba   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      s.lmr_addr = 13'($urandom);
      run_seq(s, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
